pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Pipelined successor to the combinational opcode decoder for the RV32I core, extended to RV32IM. It decodes the instruction in ID into the 14-bit control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards, holds EX for a multi-cycle multiply/divide, and squashes ID on a taken branch. Datapath registers outside this block use `stall_o` to hold PC and IF/ID.

## Interface
- `MDU_LATENCY`, 4: EX occupancy in cycles of an M-extension op (≥1)
- `HAZARD_EN`, 1: 1 enables load-use detection; 0 never stalls for loads
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `id_valid`  in  1  `id_instr` holds a real instruction
- `id_instr`  in  32  instruction in ID
- `ex_branch_taken`  in  1  branch/jump resolved taken in EX this cycle
- `stall_o`  out  1  combinational; hold PC and IF/ID
- `ex_sig`, `mem_sig`, `wb_sig`  out  14 each  control bundle per stage
- `ex_rd`, `mem_rd`, `wb_rd`  out  5 each  destination register per stage
- `ex_valid`, `mem_valid`, `wb_valid`  out  1 each  stage holds a real instruction
- `ex_mdu`  out  1  EX holds an M-extension op
- `illegal`  out  1  EX holds an undecodable opcode (`ex_valid`=1, `ex_sig`=0)
- `mdu_busy`  out  1  MDU countdown nonzero

## Operation
- Bundle bits:
  - [1:0] immsel[1:0]; [2] AluSrc; [3] MemToReg; [4] RegWrite; [5] MemRead; [6] MemWrite; [7] Branch
  - [10:8] AluOp; [11] immsel[2]; [12] offset-to-reg; [13] jalr
- Decode, bits 13..0, keyed on opcode = `id_instr[6:0]`:
  - 0110011 R: 00001000010000
  - 0010011 I: 00001000010100
  - 0000011 LOAD: 00000000111100
  - 0100011 STORE: 00000001000101
  - 1100011 BRANCH: 00010010000010
  - 0110111 LUI: 00000000010111
  - 0010111 AUIPC: 01000000010111
  - 1101111 JAL: 01110010011000
  - 1100111 JALR: 11010010011000
  - Any other opcode: 0, and `illegal` is flagged in EX.
- An M op is opcode R with `id_instr[31:25]`=0000001. It decodes to the R bundle, and `ex_mdu` is set in EX.
- Register usage:
  - rs1 = [19:15], used by all opcodes except LUI, AUIPC and JAL.
  - rs2 = [24:20], used only by R, STORE and BRANCH.
  - rd = [11:7].
- Bubble: valid=0, sig=0, rd=0, mdu=0.
- Load-use condition (only when `HAZARD_EN`=1):
  - `id_valid` & `ex_valid` & `ex_sig[5]` & `ex_rd`≠0
  - and (`ex_rd`=rs1 & rs1 used) or (`ex_rd`=rs2 & rs2 used).
- MDU state machine, counter `cnt`:
  - IDLE (`cnt`=0): when an M op is loaded into EX, `cnt` is loaded with `MDU_LATENCY`−1. With `MDU_LATENCY`=1, `cnt` stays 0 and there is no stall.
  - BUSY (`cnt`>0): `cnt` decrements each cycle. Return to IDLE when it reaches 0.
  - `mdu_busy` = (`cnt`≠0).
- Per-cycle update, priority highest first:
  1. BUSY: ID/EX holds; EX/MEM loads a bubble; `stall_o`=1; `ex_branch_taken` is ignored.
  2. `ex_branch_taken`: ID/EX loads a bubble; ID is discarded; `stall_o`=0.
  3. Load-use: ID/EX loads a bubble; `stall_o`=1.
  4. Normal: ID/EX loads the decoded ID instruction, or a bubble if `id_valid`=0; `stall_o`=0.
- In cases 2–4, EX/MEM loads from ID/EX. MEM/WB always loads from EX/MEM.

## Timing
- Reset, applied on a `clk` edge with `rst_n`=0: all three stages become bubbles, `cnt`=0, `illegal`=0, `mdu_busy`=0, `ex_mdu`=0. `stall_o`=0 for as long as `rst_n`=0.
- Reset mid-MDU abandons the op; it never reaches MEM.
- Latency without stalls: an instruction in ID at edge n appears in EX after n+1, MEM after n+2, WB after n+3.
- Load-use costs exactly 1 bubble. The consumer re-decodes the following cycle and is no longer dependent.
- M op: stays in EX for `MDU_LATENCY` cycles; `stall_o` is high for `MDU_LATENCY`−1 cycles.
- `stall_o` is a combinational function of the current registers and ID inputs, with no added cycle of delay.
- Unknown-opcode instructions flow through all stages as valid with sig=0; they write nothing.

## Test plan
- Reset, then a stream of `addi x1,x0,5` (0x00500093): `ex_sig`=00001000010100 and `ex_rd`=1 one cycle later; `wb_valid`=1 three cycles after issue; `stall_o` never asserts.
- `lw x2,0(x1)` followed by `add x3,x2,x1`: `stall_o`=1 for exactly 1 cycle, one bubble reaches MEM, then the add enters EX. Repeat with `HAZARD_EN`=0: no stall. Repeat with the load targeting x0: no stall.
- `lw x2` followed by `lui x2,1`: no stall, because LUI does not use rs1.
- `mul x5,x6,x7` with `MDU_LATENCY`=4: `ex_mdu`=1; `stall_o` and `mdu_busy` are high for 3 cycles; 3 bubbles enter MEM; the mul reaches MEM on the 4th cycle. Repeat with `MDU_LATENCY`=1: no stall.
- `ex_branch_taken`=1 while a load-use condition is present: no stall, ID/EX becomes a bubble, the ID instruction never appears in `ex_*`.
- `rst_n`=0 asserted during the 2nd MDU cycle: the next edge clears everything; the mul never appears in `mem_*`. Opcode 0x7F in ID: `illegal`=1, `ex_sig`=0.

Source files
------------

// File: rtl/pipe_ctrl_unit_if.sv
// Handshake/bus bundle between the RV32IM decode/pipeline controller and its datapath.
// slave is the controller side, master is whoever drives ID and consumes the stage bundles.
interface pipe_ctrl_unit_if;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        ex_branch_taken;
  logic        stall_o;
  logic [13:0] ex_sig;
  logic [13:0] mem_sig;
  logic [13:0] wb_sig;
  logic [4:0]  ex_rd;
  logic [4:0]  mem_rd;
  logic [4:0]  wb_rd;
  logic        ex_valid;
  logic        mem_valid;
  logic        wb_valid;
  logic        ex_mdu;
  logic        illegal;
  logic        mdu_busy;

  modport slave (
    input  id_valid, id_instr, ex_branch_taken,
    output stall_o, ex_sig, mem_sig, wb_sig, ex_rd, mem_rd, wb_rd,
           ex_valid, mem_valid, wb_valid, ex_mdu, illegal, mdu_busy
  );

  modport master (
    output id_valid, id_instr, ex_branch_taken,
    input  stall_o, ex_sig, mem_sig, wb_sig, ex_rd, mem_rd, wb_rd,
           ex_valid, mem_valid, wb_valid, ex_mdu, illegal, mdu_busy
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// RV32IM control decode carried through ID/EX, EX/MEM, MEM/WB with load-use,
// multi-cycle MDU hold and taken-branch squash.
//
// state | meaning
// IDLE  | cnt = 0, EX advances normally
// BUSY  | cnt > 0, M op held in EX, bubbles fed to MEM, stall_o high
module pipe_ctrl_unit #(
  parameter int MDU_LATENCY = 4,
  parameter bit HAZARD_EN   = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  pipe_ctrl_unit_if.slave bus
);
  localparam int CW = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LATENCY - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [13:0] dec_sig;
  logic        dec_mdu, rs1_used, rs2_used;
  logic        load_use, ex_load, load_mdu, mdu_busy;
  logic        unused_bits;

  logic        ex_valid_q, mem_valid_q, wb_valid_q, ex_mdu_q;
  logic [13:0] ex_sig_q, mem_sig_q, wb_sig_q;
  logic [4:0]  ex_rd_q, mem_rd_q, wb_rd_q;

  assign opcode      = bus.id_instr[6:0];
  assign rd          = bus.id_instr[11:7];
  assign rs1         = bus.id_instr[19:15];
  assign rs2         = bus.id_instr[24:20];
  assign unused_bits = ^bus.id_instr[14:12];

  always_comb begin
    dec_sig  = '0;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      OP_R:      begin dec_sig = 14'b00001000010000; rs2_used = 1'b1; end
      OP_I:            dec_sig = 14'b00001000010100;
      OP_LOAD:         dec_sig = 14'b00000000111100;
      OP_STORE:  begin dec_sig = 14'b00000001000101; rs2_used = 1'b1; end
      OP_BRANCH: begin dec_sig = 14'b00010010000010; rs2_used = 1'b1; end
      OP_LUI:    begin dec_sig = 14'b00000000010111; rs1_used = 1'b0; end
      OP_AUIPC:  begin dec_sig = 14'b01000000010111; rs1_used = 1'b0; end
      OP_JAL:    begin dec_sig = 14'b01110010011000; rs1_used = 1'b0; end
      OP_JALR:         dec_sig = 14'b11010010011000;
      default:         dec_sig = '0;
    endcase
  end

  assign dec_mdu = (opcode == OP_R) && (bus.id_instr[31:25] == 7'b0000001);

  always_comb begin
    load_use = 1'b0;
    if (HAZARD_EN && bus.id_valid && ex_valid_q && ex_sig_q[5] && (ex_rd_q != 5'd0))
      load_use = ((ex_rd_q == rs1) && rs1_used) || ((ex_rd_q == rs2) && rs2_used);
  end

  assign mdu_busy = (cnt != '0);
  assign ex_load  = bus.id_valid && !bus.ex_branch_taken && !load_use;
  assign load_mdu = !mdu_busy && ex_load && dec_mdu;

  // Gated by rst_n so the datapath is never held while reset is asserted.
  assign bus.stall_o = rst_n && (mdu_busy || (!bus.ex_branch_taken && load_use));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (load_mdu && (MDU_LATENCY > 1)) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CW'(1)) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_sig_q    <= '0;
      ex_rd_q     <= '0;
      ex_mdu_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_sig_q   <= '0;
      mem_rd_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_sig_q    <= '0;
      wb_rd_q     <= '0;
    end else begin
      wb_valid_q <= mem_valid_q;
      wb_sig_q   <= mem_sig_q;
      wb_rd_q    <= mem_rd_q;
      if (mdu_busy) begin
        mem_valid_q <= 1'b0;
        mem_sig_q   <= '0;
        mem_rd_q    <= '0;
      end else begin
        mem_valid_q <= ex_valid_q;
        mem_sig_q   <= ex_sig_q;
        mem_rd_q    <= ex_rd_q;
        ex_valid_q  <= ex_load;
        ex_sig_q    <= ex_load ? dec_sig : '0;
        ex_rd_q     <= ex_load ? rd : '0;
        ex_mdu_q    <= ex_load && dec_mdu;
      end
    end
  end

  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_sig    = ex_sig_q;
  assign bus.ex_rd     = ex_rd_q;
  assign bus.ex_mdu    = ex_mdu_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_sig   = mem_sig_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_sig    = wb_sig_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.mdu_busy  = mdu_busy;
  assign bus.illegal   = ex_valid_q && (ex_sig_q == '0);
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two instances (LAT=4/hazard on, LAT=1/hazard off) share
// one ID stream and are compared every cycle against an instruction-level model.
module tb_pipe_ctrl_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic        drv_valid;
  logic [31:0] drv_instr;
  logic        drv_br;

  always #5 clk = ~clk;

  pipe_ctrl_unit_if bus_a ();
  pipe_ctrl_unit_if bus_b ();

  assign bus_a.id_valid        = drv_valid;
  assign bus_a.id_instr        = drv_instr;
  assign bus_a.ex_branch_taken = drv_br;
  assign bus_b.id_valid        = drv_valid;
  assign bus_b.id_instr        = drv_instr;
  assign bus_b.ex_branch_taken = drv_br;

  pipe_ctrl_unit #(.MDU_LATENCY(4), .HAZARD_EN(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  pipe_ctrl_unit #(.MDU_LATENCY(1), .HAZARD_EN(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  localparam logic [13:0] S_R  = 14'b00001000010000;
  localparam logic [13:0] S_I  = 14'b00001000010100;

  typedef struct packed {
    logic        stall;
    logic [19:0] ex;
    logic [19:0] mem;
    logic [19:0] wb;
    logic        mdu;
    logic        ill;
    logic        busy;
  } obs_t;

  typedef struct packed {
    logic        v;
    logic [13:0] sig;
    logic [4:0]  rd;
    logic        mdu;
  } ent_t;

  obs_t obs_a, obs_b;
  assign obs_a = {bus_a.stall_o, bus_a.ex_valid, bus_a.ex_sig, bus_a.ex_rd,
                  bus_a.mem_valid, bus_a.mem_sig, bus_a.mem_rd,
                  bus_a.wb_valid, bus_a.wb_sig, bus_a.wb_rd,
                  bus_a.ex_mdu, bus_a.illegal, bus_a.mdu_busy};
  assign obs_b = {bus_b.stall_o, bus_b.ex_valid, bus_b.ex_sig, bus_b.ex_rd,
                  bus_b.mem_valid, bus_b.mem_sig, bus_b.mem_rd,
                  bus_b.wb_valid, bus_b.wb_sig, bus_b.wb_rd,
                  bus_b.ex_mdu, bus_b.illegal, bus_b.mdu_busy};

  // Model: each stage holds an instruction record; age counts cycles spent in EX.
  ent_t m_ex[2], m_mem[2], m_wb[2];
  int   age[2];
  int   lat[2] = '{4, 1};
  bit   haz[2] = '{1'b1, 1'b0};

  int n_cmp = 0;
  int n_bad = 0;
  int st_a, st_b, bz_a;
  bit last_stall_a;
  bit mul_in_mem;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [13:0] ref_sig(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return S_R;
      7'b0010011: return S_I;
      7'b0000011: return 14'b00000000111100;
      7'b0100011: return 14'b00000001000101;
      7'b1100011: return 14'b00010010000010;
      7'b0110111: return 14'b00000000010111;
      7'b0010111: return 14'b01000000010111;
      7'b1101111: return 14'b01110010011000;
      7'b1100111: return 14'b11010010011000;
      default:    return 14'b0;
    endcase
  endfunction

  function automatic bit ref_lu(input int k);
    logic [6:0] op;
    bit u1, u2;
    op = drv_instr[6:0];
    u1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    return haz[k] && drv_valid && m_ex[k].v && m_ex[k].sig[5] && (m_ex[k].rd != 5'd0) &&
           (((m_ex[k].rd == drv_instr[19:15]) && u1) || ((m_ex[k].rd == drv_instr[24:20]) && u2));
  endfunction

  function automatic bit ref_hold(input int k);
    return m_ex[k].mdu && (age[k] < lat[k]);
  endfunction

  task automatic check_dut(input int k, input obs_t o);
    string sfx;
    bit    hold;
    sfx  = (k == 0) ? "_a" : "_b";
    hold = ref_hold(k);
    chk({"stall", sfx}, 32'(o.stall), 32'(rst_n && (hold || (!drv_br && ref_lu(k)))));
    chk({"ex", sfx},    32'(o.ex),    32'({m_ex[k].v, m_ex[k].sig, m_ex[k].rd}));
    chk({"mem", sfx},   32'(o.mem),   32'({m_mem[k].v, m_mem[k].sig, m_mem[k].rd}));
    chk({"wb", sfx},    32'(o.wb),    32'({m_wb[k].v, m_wb[k].sig, m_wb[k].rd}));
    chk({"ex_mdu", sfx}, 32'(o.mdu),  32'(m_ex[k].mdu));
    chk({"illegal", sfx}, 32'(o.ill), 32'(m_ex[k].v && (m_ex[k].sig == 14'd0)));
    chk({"busy", sfx},  32'(o.busy),  32'(hold));
  endtask

  task automatic model_step(input int k);
    bit hold, lu;
    if (!rst_n) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; age[k] = 0;
    end else begin
      hold = ref_hold(k);
      lu   = ref_lu(k);
      m_wb[k] = m_mem[k];
      if (hold) begin
        m_mem[k] = '0;
        age[k]++;
      end else begin
        m_mem[k] = m_ex[k];
        if (drv_valid && !drv_br && !lu) begin
          m_ex[k] = '{v: 1'b1, sig: ref_sig(drv_instr), rd: drv_instr[11:7],
                      mdu: (drv_instr[6:0] == 7'b0110011) && (drv_instr[31:25] == 7'b0000001)};
          age[k]  = 1;
        end else begin
          m_ex[k] = '0;
          age[k]  = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_dut(0, obs_a);
    check_dut(1, obs_b);
    if (obs_a.stall) st_a++;
    if (obs_a.busy)  bz_a++;
    if (obs_b.stall) st_b++;
    if (obs_a.mem == {1'b1, S_R, 5'd5}) mul_in_mem = 1'b1;
    last_stall_a = obs_a.stall;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic br);
    drv_valid = v;
    drv_instr = ins;
    drv_br    = br;
  endtask

  task automatic clr_cnt();
    st_a = 0; st_b = 0; bz_a = 0;
  endtask

  task automatic drain(input int n);
    drive(1'b0, 32'h0, 1'b0);
    repeat (n) cycle();
  endtask

  // Present one instruction and keep it in ID while instance A stalls.
  task automatic issue(input logic [31:0] ins, input logic br);
    int n;
    n = 0;
    drive(1'b1, ins, br);
    cycle();
    drive(1'b1, ins, 1'b0);
    while (last_stall_a && n < 20) begin
      cycle();
      n++;
    end
    chk("issue_bound", 32'(n < 20), 32'd1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 10))
      0: r[6:0] = 7'b0110011;
      1: r[6:0] = 7'b0010011;
      2: r[6:0] = 7'b0000011;
      3: r[6:0] = 7'b0100011;
      4: r[6:0] = 7'b1100011;
      5: r[6:0] = 7'b0110111;
      6: r[6:0] = 7'b0010111;
      7: r[6:0] = 7'b1101111;
      8: r[6:0] = 7'b1100111;
      9: r[6:0] = 7'b0000011;
      default: r[6:0] = 7'b1111111;
    endcase
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    r[31:25] = ($urandom_range(0, 1) == 0) ? 7'b0000001 : 7'b0000000;
    return r;
  endfunction

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] LW2  = 32'h0000A103;
  localparam logic [31:0] LW0  = 32'h0000A003;
  localparam logic [31:0] ADD3 = 32'h001101B3;
  localparam logic [31:0] ADDX0 = 32'h001001B3;
  localparam logic [31:0] LUI2 = 32'h00001137;
  localparam logic [31:0] MUL  = 32'h027302B3;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; age[k] = 0;
    end
    clr_cnt();
    mul_in_mem = 1'b0;
    last_stall_a = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    cycle();
    drive(1'b1, LW2, 1'b0);
    cycle();
    drive(1'b1, ADD3, 1'b0);
    cycle();
    rst_n = 1'b1;
    drain(1);

    clr_cnt();
    issue(ADDI, 1'b0);
    chk("addi_ex_sig", 32'(bus_a.ex_sig), 32'(S_I));
    chk("addi_ex_rd", 32'(bus_a.ex_rd), 32'd1);
    repeat (4) issue(ADDI, 1'b0);
    drain(4);
    chk("addi_no_stall", st_a, 0);

    clr_cnt();
    issue(LW2, 1'b0);
    issue(ADD3, 1'b0);
    drain(4);
    chk("lu_stall_a", st_a, 1);
    chk("lu_stall_b", st_b, 0);

    clr_cnt();
    issue(LW0, 1'b0);
    issue(ADDX0, 1'b0);
    drain(4);
    chk("lu_x0_stall", st_a, 0);

    clr_cnt();
    issue(LW2, 1'b0);
    issue(LUI2, 1'b0);
    drain(4);
    chk("lu_lui_stall", st_a, 0);

    clr_cnt();
    issue(MUL, 1'b0);
    chk("mul_ex_mdu", 32'(bus_a.ex_mdu), 32'd1);
    issue(ADDI, 1'b0);
    drain(4);
    chk("mul_stall_a", st_a, 3);
    chk("mul_busy_a", bz_a, 3);
    chk("mul_stall_b", st_b, 0);

    issue(LW2, 1'b0);
    issue(ADD3, 1'b1);
    chk("br_ex_bubble", 32'(bus_a.ex_valid), 32'd0);
    drain(4);

    mul_in_mem = 1'b0;
    issue(MUL, 1'b0);
    drain(1);
    rst_n = 1'b0;
    cycle();
    chk("rst_ex_valid", 32'(bus_a.ex_valid), 32'd0);
    chk("rst_busy", 32'(bus_a.mdu_busy), 32'd0);
    rst_n = 1'b1;
    drain(6);
    chk("rst_mul_not_in_mem", 32'(mul_in_mem), 32'd0);

    issue(32'h0000007F, 1'b0);
    chk("illegal_flag", 32'(bus_a.illegal), 32'd1);
    chk("illegal_sig", 32'(bus_a.ex_sig), 32'd0);
    drain(4);

    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      drive($urandom_range(0, 4) != 0, rand_instr(), $urandom_range(0, 6) == 0);
      cycle();
    end
    rst_n = 1'b1;
    drain(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
